// File: rtl/packet_merge_arbiter_pkg.sv
// Shared router definitions: source-select encoding, default sizing and
// small helpers used by the merge arbiter and its round-robin picker.
package packet_merge_arbiter_pkg;

    localparam int DEF_DATA_WIDTH = 23;
    localparam int DEF_CREDITS    = 4;
    localparam int DEF_CW         = 3;

    typedef enum logic [1:0] {
        SRC_A = 2'd0,
        SRC_B = 2'd1,
        SRC_C = 2'd2
    } src_e;

    // Isolate the lowest set bit of a 3-bit request vector.
    function automatic logic [2:0] first_one3(input logic [2:0] v);
        return v & (~v + 3'd1);
    endfunction

    // Encode a one-hot grant as a source index (A when nothing is set).
    function automatic src_e onehot_to_src(input logic [2:0] g);
        if (g[1])      return SRC_B;
        else if (g[2]) return SRC_C;
        else           return SRC_A;
    endfunction

    // Round-robin successor: A -> B -> C -> A.
    function automatic src_e src_next(input src_e s);
        case (s)
            SRC_A:   return SRC_B;
            SRC_B:   return SRC_C;
            default: return SRC_A;
        endcase
    endfunction

endpackage

// File: rtl/packet_merge_arbiter_if.sv
// Bundle of the three FIFO read ports, the merged output and the credit
// return path. The slave modport is the arbiter's view.
interface packet_merge_arbiter_if
    import packet_merge_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
);
    logic                  empty_a, empty_b, empty_c;
    logic [DATA_WIDTH-1:0] din_a, din_b, din_c;
    logic                  ren_a, ren_b, ren_c;
    logic [DATA_WIDTH-1:0] dout;
    logic                  wen;
    logic                  credit_ret;
    logic                  credit_err;

    modport slave (
        input  empty_a, empty_b, empty_c,
        input  din_a, din_b, din_c,
        output ren_a, ren_b, ren_c,
        output dout, wen,
        input  credit_ret,
        output credit_err
    );

    modport master (
        output empty_a, empty_b, empty_c,
        output din_a, din_b, din_c,
        input  ren_a, ren_b, ren_c,
        input  dout, wen,
        output credit_ret,
        input  credit_err
    );
endinterface

// File: rtl/packet_merge_arbiter_rr_arbiter3.sv
// Combinational 3-way round-robin picker: the search starts at the pointer
// and wraps A -> B -> C -> A; the first requester found gets a one-hot grant.
module packet_merge_arbiter_rr_arbiter3
    import packet_merge_arbiter_pkg::*;
(
    input  logic [2:0] i_req,
    input  src_e       i_ptr,
    output logic [2:0] o_grant
);
    logic [2:0] w_rot;
    logic [2:0] w_pick;

    // Rotate requests so the pointer lands on bit 0, pick lowest, rotate back.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path through the case leaves it unassigned (which infers a latch).
        w_rot   = i_req;
        w_pick  = 3'b000;
        o_grant = 3'b000;
        case (i_ptr)
            SRC_B: begin
                w_rot   = {i_req[0], i_req[2], i_req[1]};
                w_pick  = first_one3(w_rot);
                o_grant = {w_pick[1], w_pick[0], w_pick[2]};
            end
            SRC_C: begin
                w_rot   = {i_req[1], i_req[0], i_req[2]};
                w_pick  = first_one3(w_rot);
                o_grant = {w_pick[0], w_pick[2], w_pick[1]};
            end
            default: begin
                w_pick  = first_one3(w_rot);
                o_grant = w_pick;
            end
        endcase
    end

endmodule

// File: rtl/packet_merge_arbiter.sv
// Merges three buffered single-flit streams into one output. One source is
// popped per cycle in round-robin order and its flit is forwarded a cycle
// later; a credit counter keeps the downstream buffer from overflowing.
module packet_merge_arbiter
    import packet_merge_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int CREDITS    = DEF_CREDITS,
    parameter int CW         = DEF_CW
)(
    input  logic                    clk,
    input  logic                    rst,
    packet_merge_arbiter_if.slave   bus
);
    localparam logic [CW-1:0] CREDITS_MAX = CW'(CREDITS);
    localparam logic [CW-1:0] ONE         = CW'(1);

    logic [CW-1:0] r_credits;
    src_e          r_ptr;
    src_e          r_sel;
    logic          r_issue;
    logic          r_err;

    logic [2:0]    w_req;
    logic [2:0]    w_grant;
    logic          w_issue;
    src_e          w_grant_src;

    // Requests are masked while in reset or out of credits, so no pop can
    // happen then and the counter can never underflow.
    assign w_req = (r_credits != '0 && !rst)
                 ? {~bus.empty_c, ~bus.empty_b, ~bus.empty_a}
                 : 3'b000;

    packet_merge_arbiter_rr_arbiter3 u_rr_arbiter3 (
        .i_req   (w_req),
        .i_ptr   (r_ptr),
        .o_grant (w_grant)
    );

    assign w_issue     = |w_grant;
    assign w_grant_src = onehot_to_src(w_grant);

    assign bus.ren_a      = w_grant[0];
    assign bus.ren_b      = w_grant[1];
    assign bus.ren_c      = w_grant[2];
    assign bus.wen        = r_issue;
    assign bus.credit_err = r_err;

    // Issue pipeline, round-robin pointer, credit counter and sticky error.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (rst) begin
            r_credits <= CREDITS_MAX;
            r_ptr     <= SRC_A;
            r_sel     <= SRC_A;
            r_issue   <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_issue <= w_issue;
            if (w_issue) begin
                r_sel <= w_grant_src;
                r_ptr <= src_next(w_grant_src);
            end
            case ({w_issue, bus.credit_ret})
                2'b10: r_credits <= r_credits - ONE;
                2'b01: begin
                    if (r_credits == CREDITS_MAX) r_err     <= 1'b1;
                    else                          r_credits <= r_credits + ONE;
                end
                default: ;
            endcase
        end
    end

    // Output mux on the registered select; the FIFO presents data now.
    always_comb begin
        bus.dout = bus.din_a;
        case (r_sel)
            SRC_B:   bus.dout = bus.din_b;
            SRC_C:   bus.dout = bus.din_c;
            default: bus.dout = bus.din_a;
        endcase
    end

endmodule

// File: tb/tb_packet_merge_arbiter.sv
// Directed bench for packet_merge_arbiter: three behavioural FIFOs feed the
// arbiter and each step compares outputs with hand-computed values.
module tb_packet_merge_arbiter;
    import packet_merge_arbiter_pkg::*;

    localparam int DW = 23;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    packet_merge_arbiter_if #(.DATA_WIDTH(DW)) bus ();

    packet_merge_arbiter #(.DATA_WIDTH(DW), .CREDITS(4), .CW(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Synchronous-read source FIFOs: index 0=A, 1=B, 2=C.
    logic [DW-1:0] mem [3][16];
    int wp [3] = '{0, 0, 0};
    int rp [3] = '{0, 0, 0};

    assign bus.empty_a = (wp[0] == rp[0]);
    assign bus.empty_b = (wp[1] == rp[1]);
    assign bus.empty_c = (wp[2] == rp[2]);

    always @(posedge clk) begin
        if (bus.ren_a) begin bus.din_a <= mem[0][rp[0] % 16]; rp[0] <= rp[0] + 1; end
        if (bus.ren_b) begin bus.din_b <= mem[1][rp[1] % 16]; rp[1] <= rp[1] + 1; end
        if (bus.ren_c) begin bus.din_c <= mem[2][rp[2] % 16]; rp[2] <= rp[2] + 1; end
    end

    int vectors     = 0;
    int miscompares = 0;
    int wen_cnt;

    logic [2:0]    exp_ren [3] = '{3'b001, 3'b010, 3'b100};
    logic [DW-1:0] exp_dat [9] = '{23'h000A01, 23'h0000E2, 23'h0000F2,
                                   23'h000A02, 23'h0000E3, 23'h0000F3,
                                   23'h000A03, 23'h0000E4, 23'h0000F4};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int s, input logic [DW-1:0] d);
        mem[s][wp[s] % 16] = d;
        wp[s] = wp[s] + 1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [2:0] rens();
        return {bus.ren_c, bus.ren_b, bus.ren_a};
    endfunction

    initial begin
        bus.credit_ret = 1'b0;
        rst = 1'b1;
        step(); step();

        // Reset state; a non-empty source is not popped while in reset.
        check("rst_wen", bus.wen, 0);
        check("rst_err", bus.credit_err, 0);
        push(0, 23'h000111); #1;
        check("rst_ren_gated", rens(), 3'b000);

        // First grant after release goes to A.
        step(); rst = 1'b0; #1;
        check("first_grant_a", rens(), 3'b001);
        step();
        check("a_wen", bus.wen, 1);
        check("a_dout", bus.dout, 23'h000111);
        check("a_ren_idle", rens(), 3'b000);

        // Single source B.
        push(1, 23'h000ABC); #1;
        check("b_only_ren", rens(), 3'b010);
        step();
        check("b_wen", bus.wen, 1);
        check("b_dout", bus.dout, 23'h000ABC);

        // Single source C (credits now 1, pointer back to A afterwards).
        push(2, 23'h00C0DE); #1;
        check("c_only_ren", rens(), 3'b100);
        step();
        check("c_dout", bus.dout, 23'h00C0DE);

        // Issue and return in the same cycle at credits=1: count stays 1.
        push(0, 23'h0000D1); push(0, 23'h0000D2); push(0, 23'h0000D3);
        bus.credit_ret = 1'b1; #1;
        check("simul_ren", rens(), 3'b001);
        step(); bus.credit_ret = 1'b0; #1;
        check("simul_dout", bus.dout, 23'h0000D1);
        check("simul_credit_kept", rens(), 3'b001);
        step();
        check("d2_dout", bus.dout, 23'h0000D2);
        check("credits_zero_block", rens(), 3'b000);

        // One credit return releases exactly one more flit a cycle later.
        bus.credit_ret = 1'b1; #1;
        check("ret_cycle_no_ren", rens(), 3'b000);
        step(); bus.credit_ret = 1'b0; #1;
        check("ret_unblocks", rens(), 3'b001);
        check("ret_wen_gap", bus.wen, 0);
        step();
        check("d3_dout", bus.dout, 23'h0000D3);

        // Reset during back-to-back traffic from B and C.
        for (int k = 1; k <= 4; k++) begin
            push(1, DW'(32'hE0 + k));
            push(2, DW'(32'hF0 + k));
        end
        bus.credit_ret = 1'b1; #1;
        check("mid_no_credit", rens(), 3'b000);
        step(); #1;
        check("mid_grant_b", rens(), 3'b010);
        step(); #1;
        check("mid_grant_c", rens(), 3'b100);
        check("mid_dout_e1", bus.dout, 23'h0000E1);
        step(); rst = 1'b1; bus.credit_ret = 1'b0; #1;
        check("rst_ren_off", rens(), 3'b000);
        check("rst_inflight_wen", bus.wen, 1);
        check("rst_inflight_dout", bus.dout, 23'h0000F1);
        step();
        check("rst_wen_cleared", bus.wen, 0);

        // Full contention with a credit return every cycle: A,B,C repeating.
        push(0, 23'h000A01); push(0, 23'h000A02); push(0, 23'h000A03);
        rst = 1'b0; bus.credit_ret = 1'b1; #1;
        for (int i = 0; i < 9; i++) begin
            check("cont_ren", rens(), exp_ren[i % 3]);
            check("cont_wen", bus.wen, i > 0);
            if (i > 0) check("cont_dout", bus.dout, exp_dat[i-1]);
            step();
        end
        bus.credit_ret = 1'b0; #1;
        check("cont_last_dout", bus.dout, exp_dat[8]);
        check("cont_drained", rens(), 3'b000);
        step();
        check("cont_end_wen", bus.wen, 0);
        check("cont_no_err", bus.credit_err, 0);

        // Credit exhaustion: six flits in A, no returns -> four writes.
        for (int k = 1; k <= 6; k++) push(0, DW'(32'h600 + k));
        #1;
        wen_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            wen_cnt += int'(bus.wen);
            step();
        end
        check("exhaust_wen_count", wen_cnt, 4);
        check("exhaust_ren_off", rens(), 3'b000);

        // Drain the two remaining flits with one return each.
        for (int k = 0; k < 2; k++) begin
            bus.credit_ret = 1'b1; #1;
            check("drain_wait", rens(), 3'b000);
            step(); bus.credit_ret = 1'b0; #1;
            check("drain_ren", rens(), 3'b001);
            step();
            check("drain_dout", bus.dout, DW'(32'h605 + k));
        end

        // Overflow: credit return at full count sets the sticky error.
        rst = 1'b1; step(); rst = 1'b0; #1;
        check("ovf_pre_err", bus.credit_err, 0);
        bus.credit_ret = 1'b1;
        step(); bus.credit_ret = 1'b0; #1;
        check("ovf_err_set", bus.credit_err, 1);
        check("ovf_no_wen", bus.wen, 0);
        step(); step();
        check("ovf_err_sticky", bus.credit_err, 1);

        // Count saturated at 4: five flits yield exactly four writes.
        for (int k = 1; k <= 5; k++) push(0, DW'(32'h700 + k));
        #1;
        wen_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            wen_cnt += int'(bus.wen);
            step();
        end
        check("ovf_sat_count", wen_cnt, 4);

        rst = 1'b1; step();
        check("rst_clears_err", bus.credit_err, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
